alu_shift_exec: RTL
===================

Name: alu_shift_exec

Overview:
- Parametrised successor of the execute-stage ALU/shifter datapath.
- Contains a barrel shifter, an ARM-style 16-op ALU, an operand-select mux (register/PC, shifter/imm12/branch offset) and the F/NZCV result registers.
- Adds a valid/ready handshake, registered Shift_Out and an optional iterative multiplier FSM (MUL/MLA).
- Sits between decode/register-read and writeback in the multi-cycle CPU.

Parameters:
- DATA_W, 32: datapath width; must be ≥ 8.
- SHAMT_W, 8: width of the shift amount.
- IMM_W, 24: branch-offset field width. It is sign-extended, then shifted left by 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept; an op is accepted on an edge where in_valid && in_ready.
- SHIFT_OP  in  3  0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX, 5-7 pass-through (carry = CF).
- Shift_Data  in  DATA_W  shifter operand.
- Shift_Num  in  SHAMT_W  shift amount.
- ALU_OP  in  4  ARM DP encoding: 0 AND, 1 EOR, 2 SUB, 3 RSB, 4 ADD, 5 ADC, 6 SBC, 7 RSC, 8 TST, 9 TEQ, 10 CMP, 11 CMN, 12 ORR, 13 MOV, 14 BIC, 15 MVN.
- MUL_OP  in  2  0 none, 1 MUL, 2 MLA, 3 reserved (treated as 0).
- A_New  in  DATA_W  register operand A.
- PC  in  DATA_W  program counter.
- Acc  in  DATA_W  MLA addend.
- ALU_A_s  in  1  1 = A is PC, 0 = A is A_New.
- ALU_B_s  in  2  bit1 = zero-extended imm12; else bit0 = sign-extended imm24 shifted left by 2; else Shift_Out.
- imm24  in  IMM_W  branch offset.
- imm12  in  12  immediate.
- S  in  1  update NZCV.
- LF  in  1  load F.
- F  out  DATA_W  result register.
- NZCV  out  4  flag register; bit3 = N, bit0 = V.
- Shift_Out  out  DATA_W  registered shifter result.
- out_valid  out  1  one-cycle pulse when F/NZCV reflect a completed op.
- busy  out  1  multiplier FSM not IDLE.

Behaviour:
- Reset (synchronous, Rst high at an edge):
  - F, NZCV, Shift_Out = 0; out_valid = 0; FSM to IDLE; in_ready = 1.
  - Reset during MUL_RUN aborts the multiply with no writeback.
- ALU inputs at an accepting edge:
  - The ALU computes combinationally from the current inputs and the current NZCV register, which supplies CF and VF.
  - Back-to-back ops therefore see the prior op's flags with no hazard.
- Single-cycle op (MUL_OP = 0), at the accepting edge:
  - Shift_Out is loaded.
  - F is loaded if LF.
  - NZCV is loaded if S.
  - out_valid = 1 for the following cycle.
- Shifter, with n = Shift_Num:
  - n = 0 (LSL/LSR/ASR/ROR): data unchanged, carry = CF.
  - LSL, 0 < n < DATA_W: carry = bit[DATA_W-n]. n = DATA_W: out 0, carry = bit0. n > DATA_W: out 0, carry 0.
  - LSR: mirror of LSL; n = DATA_W gives carry = MSB.
  - ASR, n ≥ DATA_W: all bits = MSB, carry = MSB.
  - ROR: rotate by n mod DATA_W; carry = result MSB.
  - RRX: output {CF, data[DATA_W-1:1]}, carry = bit0.
- ALU flags:
  - Logical ops: C = shifter carry, V unchanged.
  - Arithmetic ops: C = carry-out. For SUB/RSB/SBC/RSC/CMP, C = NOT borrow.
  - V = signed overflow.
  - N = MSB; Z = result == 0.
  - TST/TEQ/CMP/CMN never load F, even if LF = 1.
- Multiply (MUL_OP = 1 or 2), FSM IDLE → MUL_RUN → MUL_DONE → IDLE:
  - On accept: latch A (post-mux), B (post-mux) and Acc. in_ready drops the next cycle; busy = 1.
  - MUL_RUN: radix-2 shift-add, one multiplier bit per cycle, DATA_W cycles. Inputs may change freely.
  - MUL_DONE: F = low DATA_W bits of A*B (+Acc for MLA), loaded if LF latched. If S latched, N and Z are updated and C, V are preserved. out_valid pulses. Next cycle: IDLE, in_ready = 1.
  - Latency: accept edge to out_valid = DATA_W+1 cycles.
- in_valid while in_ready = 0: ignored; the requester must hold.
- Shift_Out for multiply ops: updated at accept like any op.

Optional Feature:
- ALU_SHIFT_MUL_EN defined: multiplier FSM present as above.
- Not defined:
  - MUL_OP is ignored and treated as 0.
  - in_ready is tied to 1 and busy to 0.
  - Every op completes in one cycle.
  - No multiplier logic is instantiated.

Test Plan:
- Reset then idle: after Rst=1 for one edge, F=0, NZCV=0, Shift_Out=0, out_valid=0, in_ready=1.
- ADD with S, LF: A_New=0x7FFFFFFF, Shift_Data=1 LSL 0, ALU_OP=4, S=1, LF=1 → next cycle F=0x80000000, NZCV=1001, out_valid pulse.
- SUB then ADC back-to-back: SUB 5-5 → NZCV=0110. Then ADC 1+1 → F=3.
- Shift boundaries: LSR 0x80000001 by 32 → Shift_Out=0, C=1. ASR 0x80000000 by 40 → 0xFFFFFFFF, C=1. RRX 0x00000001 with CF=1 → 0x80000000, C=1.
- Branch target: ALU_A_s=1, PC=0x100, ALU_B_s=01, imm24=0xFFFFFF, ADD, LF=1 → F=0xFC.
- MLA (macro defined): A=7, B=6, Acc=3, MUL_OP=2, S=1, LF=1 → in_ready low 33 cycles, then F=45, N=0, Z=0, C and V unchanged. Asserting Rst at cycle 10 of the run → F=0, FSM IDLE, no out_valid.

Source files
------------

// File: rtl/alu_shift_exec_if.sv
// Operation/result bundle between register-read and the alu_shift_exec execute stage.
// master = issuing side (decode/register-read), slave = the execute stage.
interface alu_shift_exec_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 8,
  parameter int IMM_W   = 24
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         SHIFT_OP;
  logic [DATA_W-1:0]  Shift_Data;
  logic [SHAMT_W-1:0] Shift_Num;
  logic [3:0]         ALU_OP;
  logic [1:0]         MUL_OP;
  logic [DATA_W-1:0]  A_New;
  logic [DATA_W-1:0]  PC;
  logic [DATA_W-1:0]  Acc;
  logic               ALU_A_s;
  logic [1:0]         ALU_B_s;
  logic [IMM_W-1:0]   imm24;
  logic [11:0]        imm12;
  logic               S;
  logic               LF;
  logic [DATA_W-1:0]  F;
  logic [3:0]         NZCV;
  logic [DATA_W-1:0]  Shift_Out;
  logic               out_valid;
  logic               busy;

  modport master (
    output in_valid, SHIFT_OP, Shift_Data, Shift_Num, ALU_OP, MUL_OP,
           A_New, PC, Acc, ALU_A_s, ALU_B_s, imm24, imm12, S, LF,
    input  in_ready, F, NZCV, Shift_Out, out_valid, busy
  );

  modport slave (
    input  in_valid, SHIFT_OP, Shift_Data, Shift_Num, ALU_OP, MUL_OP,
           A_New, PC, Acc, ALU_A_s, ALU_B_s, imm24, imm12, S, LF,
    output in_ready, F, NZCV, Shift_Out, out_valid, busy
  );
endinterface

// File: rtl/alu_shift_exec.sv
// Execute stage: barrel shifter, ARM 16-op ALU, operand muxes and F/NZCV/Shift_Out registers.
// Define ALU_SHIFT_MUL_EN to add the iterative shift-add MUL/MLA unit.
module alu_shift_exec #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 8,
  parameter int IMM_W   = 24
) (
  input logic             clk,
  input logic             Rst,
  alu_shift_exec_if.slave bus
);
  localparam int                MSB = DATA_W - 1;
  localparam logic [31:0]       DW  = 32'(DATA_W);
  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] f_q;
  logic [DATA_W-1:0] shift_q;
  logic [3:0]        nzcv_q;
  logic              out_valid_q;
  logic              cf;
  logic              ready_int;
  logic              is_mul;
  logic              accept;

  assign cf     = nzcv_q[1];
  assign accept = bus.in_valid && ready_int;

  function automatic logic bit_at(input logic [DATA_W-1:0] v, input logic [31:0] idx);
    return |(v & (ONE << idx));
  endfunction

  logic [DATA_W-1:0] sh_data;
  logic [DATA_W-1:0] sh_out;
  logic [31:0]       sh_n;
  logic [31:0]       rot_n;
  logic              sh_c;

  always_comb begin
    sh_data = bus.Shift_Data;
    sh_n    = 32'(bus.Shift_Num);
    rot_n   = sh_n % DW;
    sh_out  = sh_data;
    sh_c    = cf;
    case (bus.SHIFT_OP)
      3'd0: begin
        if (sh_n == '0) begin
          sh_out = sh_data;
        end else if (sh_n < DW) begin
          sh_out = sh_data << sh_n;
          sh_c   = bit_at(sh_data, DW - sh_n);
        end else begin
          sh_out = '0;
          sh_c   = (sh_n == DW) ? sh_data[0] : 1'b0;
        end
      end
      3'd1: begin
        if (sh_n == '0) begin
          sh_out = sh_data;
        end else if (sh_n < DW) begin
          sh_out = sh_data >> sh_n;
          sh_c   = bit_at(sh_data, sh_n - 32'd1);
        end else begin
          sh_out = '0;
          sh_c   = (sh_n == DW) ? sh_data[MSB] : 1'b0;
        end
      end
      3'd2: begin
        if (sh_n == '0) begin
          sh_out = sh_data;
        end else if (sh_n < DW) begin
          sh_out = $signed(sh_data) >>> sh_n;
          sh_c   = bit_at(sh_data, sh_n - 32'd1);
        end else begin
          sh_out = {DATA_W{sh_data[MSB]}};
          sh_c   = sh_data[MSB];
        end
      end
      3'd3: begin
        // A nonzero multiple of DATA_W leaves the data in place but still takes carry from MSB.
        if (sh_n != '0) begin
          sh_out = (sh_data >> rot_n) | (sh_data << (DW - rot_n));
          sh_c   = sh_out[MSB];
        end
      end
      3'd4: begin
        sh_out = {cf, sh_data[MSB:1]};
        sh_c   = sh_data[0];
      end
      default: begin
        sh_out = sh_data;
        sh_c   = cf;
      end
    endcase
  end

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] imm12_ext;
  logic [DATA_W-1:0] imm24_ext;

  assign imm12_ext = DATA_W'(bus.imm12);
  assign imm24_ext = DATA_W'($signed(bus.imm24)) << 2;
  assign op_a      = bus.ALU_A_s ? bus.PC : bus.A_New;
  assign op_b      = bus.ALU_B_s[1] ? imm12_ext : (bus.ALU_B_s[0] ? imm24_ext : sh_out);

  logic [DATA_W-1:0] alu_x;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W:0]   alu_sum;
  logic              alu_ci;
  logic              arith;
  logic              alu_c;
  logic              alu_v;
  logic              writes_f;

  // Every arithmetic op is x + y + ci; subtraction inverts one operand so C comes out as NOT borrow.
  always_comb begin
    alu_x  = op_a;
    alu_y  = op_b;
    alu_ci = 1'b0;
    arith  = 1'b1;
    case (bus.ALU_OP)
      4'd2, 4'd10: begin alu_y = ~op_b; alu_ci = 1'b1; end
      4'd3:        begin alu_x = op_b; alu_y = ~op_a; alu_ci = 1'b1; end
      4'd4, 4'd11: begin alu_ci = 1'b0; end
      4'd5:        begin alu_ci = cf; end
      4'd6:        begin alu_y = ~op_b; alu_ci = cf; end
      4'd7:        begin alu_x = op_b; alu_y = ~op_a; alu_ci = cf; end
      default:     begin arith = 1'b0; end
    endcase
    alu_sum = {1'b0, alu_x} + {1'b0, alu_y} + {{DATA_W{1'b0}}, alu_ci};
    case (bus.ALU_OP)
      4'd0, 4'd8: alu_res = op_a & op_b;
      4'd1, 4'd9: alu_res = op_a ^ op_b;
      4'd12:      alu_res = op_a | op_b;
      4'd13:      alu_res = op_b;
      4'd14:      alu_res = op_a & ~op_b;
      4'd15:      alu_res = ~op_b;
      default:    alu_res = alu_sum[MSB:0];
    endcase
    alu_c    = arith ? alu_sum[DATA_W] : sh_c;
    alu_v    = arith ? ((alu_x[MSB] == alu_y[MSB]) && (alu_res[MSB] != alu_x[MSB])) : nzcv_q[0];
    writes_f = (bus.ALU_OP[3:2] != 2'b10);
  end

`ifdef ALU_SHIFT_MUL_EN
  localparam int             CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(DATA_W - 1);
  localparam logic [1:0]     ST_IDLE  = 2'd0;
  localparam logic [1:0]     ST_RUN   = 2'd1;
  localparam logic [1:0]     ST_DONE  = 2'd2;

  logic [1:0]        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] prod_q;
  logic              mul_lf_q;
  logic              mul_s_q;

  assign is_mul    = (bus.MUL_OP == 2'd1) || (bus.MUL_OP == 2'd2);
  assign ready_int = (state_q == ST_IDLE);
  assign bus.busy  = (state_q != ST_IDLE);

  // The product starts at Acc for MLA so the final add is free; one multiplier bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      mul_lf_q <= 1'b0;
      mul_s_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && is_mul) begin
            mcand_q  <= op_a;
            mplier_q <= op_b;
            prod_q   <= (bus.MUL_OP == 2'd2) ? bus.Acc : '0;
            mul_lf_q <= bus.LF;
            mul_s_q  <= bus.S;
            cnt_q    <= '0;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (mplier_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
`else
  logic unused_mul;

  assign unused_mul = ^{bus.MUL_OP, bus.Acc};
  assign is_mul     = 1'b0;
  assign ready_int  = 1'b1;
  assign bus.busy   = 1'b0;
`endif

  // Result registers: single-cycle ops write at accept, multiplies write from MUL_DONE.
  always_ff @(posedge clk) begin
    if (Rst) begin
      f_q         <= '0;
      nzcv_q      <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (accept) begin
        shift_q <= sh_out;
        if (!is_mul) begin
          if (bus.LF && writes_f) f_q <= alu_res;
          if (bus.S) nzcv_q <= {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
          out_valid_q <= 1'b1;
        end
      end
`ifdef ALU_SHIFT_MUL_EN
      if (state_q == ST_DONE) begin
        if (mul_lf_q) f_q <= prod_q;
        if (mul_s_q) nzcv_q[3:2] <= {prod_q[MSB], (prod_q == '0)};
        out_valid_q <= 1'b1;
      end
`endif
    end
  end

  assign bus.in_ready  = ready_int;
  assign bus.F         = f_q;
  assign bus.NZCV      = nzcv_q;
  assign bus.Shift_Out = shift_q;
  assign bus.out_valid = out_valid_q;
endmodule
